// File: rtl/uart_pkg.sv
// Shared types and encodings for the UART transmitter: FSM states,
// data-length and parity-type codes, and helpers that decode them.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Index of the last data bit sent for a given length code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] code);
        case (code)
            DBITS_5: last_bit_idx = 3'd4;
            DBITS_6: last_bit_idx = 3'd5;
            DBITS_7: last_bit_idx = 3'd6;
            default: last_bit_idx = 3'd7;
        endcase
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] code);
        case (code)
            DBITS_5: data_mask = 8'h1F;
            DBITS_6: data_mask = 8'h3F;
            DBITS_7: data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte/config request and serial-line status bundle between a client
// (master) and the UART transmitter (slave).
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       start_tx;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic       cts_n;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data, start_tx, data_bit_num, stop_bit_num,
               parity_en, parity_type, cts_n,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, start_tx, data_bit_num, stop_bit_num,
               parity_en, parity_type, cts_n,
        output tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, restarts on frame accept,
// flags the final cycle (bit_tick) and the one before it (last_tick).
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_tick,
    output logic last_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));
    assign last_tick = (cnt == CW'(CLKS_PER_BIT - 2));
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 5-8 data bits, optional even/odd parity, 1-2 stop bits.
// Define UART_TX_CTS_EN to gate frame acceptance on cts_n (active-low).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434  // must be >= 2
) (
    input logic       clk,
    input logic       reset,
    uart_tx_if.slave  bus
);
    tx_state_e  state;
    logic       tx_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] sh_data;
    logic [2:0] sh_last;
    logic       sh_stop2;
    logic       sh_par_en;
    logic       sh_par_odd;
    logic [2:0] bit_idx;
    logic [2:0] next_idx;
    logic       stop_idx;
    logic       accept;
    logic       restart;
    logic       bit_tick;
    logic       last_tick;

`ifdef UART_TX_CTS_EN
    assign accept = bus.start_tx && !bus.cts_n;
`else
    assign accept = bus.start_tx;
`endif

    assign restart  = (state == IDLE) && accept;
    assign next_idx = bit_idx + 3'd1;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .bit_tick  (bit_tick),
        .last_tick (last_tick)
    );

    // The final stop bit ends one cycle early so that the tx_done cycle is
    // its last cycle: a start accepted then follows with no idle gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sh_data    <= '0;
            sh_last    <= '0;
            sh_stop2   <= 1'b0;
            sh_par_en  <= 1'b0;
            sh_par_odd <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_data    <= bus.tx_data & data_mask(bus.data_bit_num);
                        sh_last    <= last_bit_idx(bus.data_bit_num);
                        sh_stop2   <= bus.stop_bit_num;
                        sh_par_en  <= bus.parity_en;
                        sh_par_odd <= (bus.parity_type == PARITY_ODD);
                        bit_idx    <= '0;
                        stop_idx   <= 1'b0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx_q  <= sh_data[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx != sh_last) begin
                            bit_idx <= next_idx;
                            tx_q    <= sh_data[next_idx];
                        end else if (sh_par_en) begin
                            tx_q  <= (^sh_data) ^ sh_par_odd;
                            state <= PARITY;
                        end else begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (last_tick && (stop_idx == sh_stop2)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else if (bit_tick) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 16 clocks per bit: directed frame
// table, randomized frames against a frame model, back-to-back and reset.
module tb_uart_tx;
    localparam int CPB = 16;

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  code;
        logic        s2;
        logic        pe;
        logic        po;
        logic [11:0] eb;
        int          nb;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Serial bit sequence derived directly from the frame rules.
    function automatic void model(input logic [7:0] d, input logic [1:0] code,
                                  input logic s2, input logic pe, input logic po,
                                  output logic [11:0] eb, output int nb);
        int n;
        int ones;
        bit q[$];
        n = 5 + int'(code);
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) q.push_back(((ones % 2) == 1) ^ po);
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        eb = '0;
        nb = q.size();
        for (int i = 0; i < nb; i++) eb[i] = q[i];
    endfunction

    task automatic wait_idle();
        int guard = 0;
        while ((bus.tx_busy || bus.tx_done) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("idle_timeout", 1, 0);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [1:0] code,
                             input logic s2, input logic pe, input logic po,
                             input logic [11:0] eb, input int nb,
                             input string name, input bit mess);
        int total = nb * CPB;
        int tx_err = 0;
        int busy_err = 0;
        int done_at = -1;
        int done_cnt = 0;
        logic [11:0] rec = '0;
        logic exp_tx;
        wait_idle();
        @(negedge clk);
        bus.tx_data      = d;
        bus.data_bit_num = code;
        bus.stop_bit_num = s2;
        bus.parity_en    = pe;
        bus.parity_type  = po;
        bus.cts_n        = 1'b0;
        bus.start_tx     = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            exp_tx = (k < total) ? eb[k / CPB] : 1'b1;
            if (bus.tx !== exp_tx) tx_err++;
            if (bus.tx_busy !== (k < total - 1)) busy_err++;
            if ((k % CPB) == CPB / 2 && k < total) rec[k / CPB] = bus.tx;
            if (bus.tx_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (mess && k > 0 && k < total - 1) begin
                bus.tx_data      = 8'($urandom);
                bus.data_bit_num = 2'($urandom);
                bus.stop_bit_num = 1'($urandom);
                bus.parity_en    = 1'($urandom);
                bus.parity_type  = 1'($urandom);
                bus.cts_n        = 1'($urandom);
                bus.start_tx     = ($urandom_range(0, 7) == 0);
            end else begin
                bus.start_tx = 1'b0;
                bus.cts_n    = 1'b0;
            end
        end
        check({name, ".bits"}, int'(rec), int'(eb));
        check({name, ".tx_timing"}, tx_err, 0);
        check({name, ".busy"}, busy_err, 0);
        check({name, ".done_at"}, done_at, total - 1);
        check({name, ".done_cnt"}, done_cnt, 1);
    endtask

    vec_t tbl[4];

    initial begin
        logic [11:0] eb;
        int nb;
        int errs;
        int dones;
        logic [7:0] rd;
        logic [1:0] rc;
        logic rs, rpe, rpo;

        tbl[0] = '{d: 8'hA5, code: 2'b11, s2: 1'b0, pe: 1'b0, po: 1'b0, eb: 12'h34A, nb: 10};
        tbl[1] = '{d: 8'h41, code: 2'b10, s2: 1'b1, pe: 1'b1, po: 1'b0, eb: 12'h682, nb: 11};
        tbl[2] = '{d: 8'h1F, code: 2'b00, s2: 1'b0, pe: 1'b1, po: 1'b1, eb: 12'h0BE, nb: 8};
        tbl[3] = '{d: 8'hFF, code: 2'b01, s2: 1'b1, pe: 1'b0, po: 1'b0, eb: 12'h1FE, nb: 9};

        bus.tx_data = 8'h00; bus.start_tx = 1'b0; bus.data_bit_num = 2'b11;
        bus.stop_bit_num = 1'b0; bus.parity_en = 1'b0; bus.parity_type = 1'b0;
        bus.cts_n = 1'b0;

        repeat (3) @(negedge clk);
        check("rst.tx", int'(bus.tx), 1);
        check("rst.busy", int'(bus.tx_busy), 0);
        check("rst.done", int'(bus.tx_done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_frame(tbl[i].d, tbl[i].code, tbl[i].s2, tbl[i].pe, tbl[i].po,
                      tbl[i].eb, tbl[i].nb, $sformatf("vec%0d", i), 1'b0);

        for (int i = 0; i < 16; i++) begin
            rd = 8'($urandom); rc = 2'($urandom); rs = 1'($urandom);
            rpe = 1'($urandom); rpo = 1'($urandom);
            model(rd, rc, rs, rpe, rpo, eb, nb);
            run_frame(rd, rc, rs, rpe, rpo, eb, nb, $sformatf("rnd%0d", i), 1'b1);
        end

        // start_tx held across two frames: second start bit right after tx_done cycle
        wait_idle();
        @(negedge clk);
        bus.tx_data = 8'hA5; bus.data_bit_num = 2'b11; bus.stop_bit_num = 1'b0;
        bus.parity_en = 1'b0; bus.cts_n = 1'b0; bus.start_tx = 1'b1;
        @(posedge clk);
        errs = 0; dones = 0;
        for (int k = 0; k < 2 * 10 * CPB + 1; k++) begin
            @(negedge clk);
            if (k < 2 * 10 * CPB) begin
                if (bus.tx !== tbl[0].eb[(k % (10 * CPB)) / CPB]) errs++;
            end else if (bus.tx !== 1'b1) errs++;
            if (bus.tx_done === 1'b1) begin
                dones++;
                if (k != 10 * CPB - 1 && k != 20 * CPB - 1) errs++;
            end
            if (k == 19 * CPB) bus.start_tx = 1'b0;
        end
        check("b2b.tx", errs, 0);
        check("b2b.dones", dones, 2);

        // reset pulse 50 cycles into an 8N1 frame
        wait_idle();
        @(negedge clk);
        bus.start_tx = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            bus.start_tx = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("midrst.tx", int'(bus.tx), 1);
        check("midrst.busy", int'(bus.tx_busy), 0);
        check("midrst.done", int'(bus.tx_done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        errs = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.tx_done !== 1'b0 || bus.tx !== 1'b1) errs++;
        end
        check("midrst.quiet", errs, 0);
        model(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, eb, nb);
        run_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, eb, nb, "postrst", 1'b0);

        // flow control on cts_n
        wait_idle();
        @(negedge clk);
        bus.tx_data = 8'hA5; bus.cts_n = 1'b1; bus.start_tx = 1'b1;
`ifdef UART_TX_CTS_EN
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) errs++;
        end
        check("cts.blocked", errs, 0);
        bus.cts_n = 1'b0;
        @(negedge clk);
        check("cts.start", int'(bus.tx), 0);
`else
        @(negedge clk);
        check("cts.ignored", int'(bus.tx), 0);
`endif
        bus.start_tx = 1'b0;
        bus.cts_n = 1'b0;
        @(negedge clk);
        wait_idle();
        check("end.tx", int'(bus.tx), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
